sprite_loader: RTL and testbench

SPRITE_LOADER -- requirements
Module: sprite_loader

---
 rtl/sprite_loader_pkg.sv | 24 ++
 rtl/sprite_loader_timeout.sv | 32 +++
 rtl/sprite_loader.sv | 162 ++++++++++++++++
 tb/tb_sprite_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_loader_pkg.sv
// Shared definitions for the sprite loader: FSM encoding, frame marker, pixel format, sprite IDs.
// The CHECK state exists only when SPRITE_LOADER_CHECKSUM_EN is defined.
package sprite_loader_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         PIX_W             = 9;

  // RRRGGGBBB colour that the renderer treats as see-through.
  localparam logic [PIX_W-1:0] TRANSPARENT_KEY = 9'b111101110;

  localparam logic [1:0] SPRITE_FROG = 2'd0;
  localparam logic [1:0] SPRITE_CAR  = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    ID,
    PIX_HI,
    PIX_LO
`ifdef SPRITE_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

endpackage

// File: rtl/sprite_loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags expiry after TIMEOUT_CYCLES.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  localparam int                CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q <= '0;
    end else if (reload || !enable) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Counter reaches CNT_MAX exactly TIMEOUT_CYCLES edges after the last reload.
  assign expired = enable && (cnt_q == CNT_MAX);

endmodule

// File: rtl/sprite_loader.sv
// UART-fed sprite loader: parses SYNC/ID/pixel frames and streams 9-bit pixels into sprite memories.
// Optional trailing XOR checksum is enabled by defining SPRITE_LOADER_CHECKSUM_EN.
module sprite_loader
  import sprite_loader_pkg::*;
#(
  parameter int         TILE_SIZE      = 32,
  parameter int         NUM_SPRITES    = 2,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 2_500_000
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_RX_DV,
  input  logic [7:0]       i_RX_Byte,
  output logic             o_Wr_En,
  output logic [1:0]       o_Wr_Sel,
  output logic [9:0]       o_Wr_Addr,
  output logic [PIX_W-1:0] o_Wr_Data,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Error
);

  localparam logic [9:0] ADDR_LAST = 10'(TILE_SIZE * TILE_SIZE - 1);

  state_t state_q, state_d;
  logic   pix_hi_q;
  logic   expired;
  logic   last_pix;

  logic   err_set, err_clr, done_set, wr_set, id_load, hi_load;

`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
`else
  logic       final_wr_q;
`endif

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .reload (i_RX_DV),
    .enable (state_q != IDLE),
    .expired(expired)
  );

  // The address register already points at the pixel about to be written.
  assign last_pix = (o_Wr_Addr == ADDR_LAST);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    done_set = 1'b0;
    wr_set   = 1'b0;
    id_load  = 1'b0;
    hi_load  = 1'b0;
`ifndef SPRITE_LOADER_CHECKSUM_EN
    done_set = final_wr_q;
`endif

    if (i_RX_DV) begin
      unique case (state_q)
        IDLE: begin
          if (i_RX_Byte == SYNC_BYTE) begin
            state_d = ID;
            err_clr = 1'b1;
          end
        end
        ID: begin
          if (int'(i_RX_Byte) < NUM_SPRITES) begin
            id_load = 1'b1;
            state_d = PIX_HI;
          end else begin
            err_set = 1'b1;
            state_d = IDLE;
          end
        end
        PIX_HI: begin
          hi_load = 1'b1;
          state_d = PIX_LO;
        end
        PIX_LO: begin
          wr_set = 1'b1;
          if (!last_pix) begin
            state_d = PIX_HI;
          end else begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = IDLE;
`endif
          end
        end
`ifdef SPRITE_LOADER_CHECKSUM_EN
        CHECK: begin
          if (i_RX_Byte == csum_q) done_set = 1'b1;
          else                     err_set  = 1'b1;
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end else if (expired) begin
      // A strobe on the expiry cycle takes the branch above and reloads the watchdog.
      err_set = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Wr_En   <= 1'b0;
      o_Wr_Sel  <= '0;
      o_Wr_Addr <= '0;
      o_Wr_Data <= '0;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
      o_Error   <= 1'b0;
      pix_hi_q  <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`else
      final_wr_q <= 1'b0;
`endif
    end else begin
      o_Wr_En <= wr_set;
      o_Done  <= done_set;
      o_Busy  <= (state_d != IDLE);

      if (err_set)      o_Error <= 1'b1;
      else if (err_clr) o_Error <= 1'b0;

      if (id_load) begin
        o_Wr_Sel  <= i_RX_Byte[1:0];
        o_Wr_Addr <= '0;
      end else if (o_Wr_En && !last_pix) begin
        o_Wr_Addr <= o_Wr_Addr + 1'b1;
      end

      if (hi_load) pix_hi_q  <= i_RX_Byte[0];
      if (wr_set)  o_Wr_Data <= {pix_hi_q, i_RX_Byte};

`ifdef SPRITE_LOADER_CHECKSUM_EN
      if (id_load)                csum_q <= '0;
      else if (hi_load || wr_set) csum_q <= csum_q ^ i_RX_Byte;
`else
      final_wr_q <= wr_set && last_pix;
`endif
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Randomized scoreboard bench for sprite_loader; a monitor checks every write against queued expectations.
module tb_sprite_loader;
  import sprite_loader_pkg::*;

  localparam int TILE = 32;
  localparam int NPIX = TILE * TILE;
  localparam int TMO  = 64;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       i_Clk, i_Rst_L, i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_Wr_En, o_Busy, o_Done, o_Error;
  logic [1:0] o_Wr_Sel;
  logic [9:0] o_Wr_Addr;
  logic [8:0] o_Wr_Data;

  sprite_loader #(
    .TILE_SIZE(TILE), .NUM_SPRITES(2), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .o_Wr_En(o_Wr_En), .o_Wr_Sel(o_Wr_Sel), .o_Wr_Addr(o_Wr_Addr), .o_Wr_Data(o_Wr_Data),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Error(o_Error)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [1:0] sel;
    logic [9:0] addr;
    logic [8:0] data;
    bit         last;
  } wr_t;

  wr_t        exp_q[$];
  logic [8:0] pix[NPIX];
  logic [7:0] csum_model;
  int         checks = 0, errors = 0;
  int         done_seen = 0, done_exp = 0;
  bit         prev_final = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pops one expectation; o_Done is cross-checked too.
  always @(negedge i_Clk) begin
    bit  now_final;
    wr_t e;
    now_final = 1'b0;
    if (o_Wr_En) begin
      check("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_sel", o_Wr_Sel, e.sel);
        check("wr_addr", o_Wr_Addr, e.addr);
        check("wr_data", o_Wr_Data, e.data);
        now_final = e.last;
      end
    end
    if (o_Done) done_seen++;
`ifndef SPRITE_LOADER_CHECKSUM_EN
    if (o_Done || prev_final) check("done_timing", o_Done, prev_final);
`endif
    if (o_Done || o_Error) check("done_err_exclusive", o_Done && o_Error, 0);
    prev_final = now_final;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge i_Clk);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    @(negedge i_Clk);
    i_RX_DV   = 1'b0;
  endtask

  function automatic int rgap();
    return $urandom_range(0, 3);
  endfunction

  task automatic start_frame(input logic [1:0] sel);
    send_byte(SYNC, rgap());
    send_byte({6'd0, sel}, rgap());
    csum_model = 8'h00;
  endtask

  // Reference model: pixel i goes to address i of the selected sprite.
  task automatic send_pixels(input logic [1:0] sel, input int first, input int last,
                             input bit push, input bit junk, input int slow_idx);
    logic [7:0] hi, lo;
    wr_t        e;
    for (int i = first; i <= last; i++) begin
      hi = {(junk ? 7'($urandom) : 7'd0), pix[i][8]};
      lo = pix[i][7:0];
      send_byte(hi, (i == slow_idx) ? TMO - 1 : rgap());
      csum_model ^= hi;
      if (push) begin
        e.sel = sel; e.addr = 10'(i); e.data = pix[i]; e.last = (i == NPIX - 1);
        exp_q.push_back(e);
      end
      send_byte(lo, rgap());
      csum_model ^= lo;
    end
  endtask

  task automatic finish_frame();
`ifdef SPRITE_LOADER_CHECKSUM_EN
    send_byte(csum_model, rgap());
`endif
    done_exp++;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) begin
      pix[i] = 9'($urandom);
      if (i % 7 == 3) pix[i][7:0] = SYNC;
    end
  endtask

  task automatic expect_idle_ok(input string tag);
    repeat (4) @(negedge i_Clk);
    check({tag, "_done_count"}, done_seen, done_exp);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_error"}, o_Error, 0);
    check({tag, "_busy"}, o_Busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sel;
    i_Rst_L = 1'b0; i_RX_DV = 1'b0; i_RX_Byte = 8'h00;
    repeat (3) @(negedge i_Clk);
    check("reset_outputs", {o_Wr_En, o_Wr_Sel, o_Wr_Addr, o_Wr_Data, o_Busy, o_Done, o_Error}, 0);
    i_Rst_L = 1'b1;
    @(negedge i_Clk);

    // Frog sprite filled with the transparency key.
    for (int i = 0; i < NPIX; i++) pix[i] = TRANSPARENT_KEY;
    start_frame(SPRITE_FROG);
    send_pixels(SPRITE_FROG, 0, NPIX - 1, 1, 0, -1);
    finish_frame();
    expect_idle_ok("key_frame");

    // Bad sprite ID, then a fresh SYNC clears the error.
    send_byte(SYNC, 1);
    send_byte(8'h02, 1);
    repeat (3) @(negedge i_Clk);
    check("bad_id_error", o_Error, 1);
    check("bad_id_busy", o_Busy, 0);
    check("bad_id_no_writes", exp_q.size(), 0);
    send_byte(SYNC, 1);
    check("resync_error_clear", o_Error, 0);
    check("resync_busy", o_Busy, 1);
    send_byte({6'd0, SPRITE_CAR}, rgap());
    csum_model = 8'h00;
    fill_random();
    send_pixels(SPRITE_CAR, 0, NPIX - 1, 1, 1, -1);
    finish_frame();
    expect_idle_ok("random_frame");

    // Stall after ten pixels.
    fill_random();
    sel = 2'($urandom_range(0, 1));
    start_frame(sel);
    send_pixels(sel, 0, 9, 1, 1, -1);
    repeat (TMO + 5) @(negedge i_Clk);
    check("stall_error", o_Error, 1);
    check("stall_busy", o_Busy, 0);
    check("stall_queue_empty", exp_q.size(), 0);
    check("stall_done_count", done_seen, done_exp);

    // Byte lands exactly on the expiry cycle.
    fill_random();
    sel = 2'($urandom_range(0, 1));
    start_frame(sel);
    send_pixels(sel, 0, NPIX - 1, 1, 1, 300);
    finish_frame();
    expect_idle_ok("edge_frame");

    // Asynchronous reset after 500 pixels.
    fill_random();
    start_frame(SPRITE_FROG);
    send_pixels(SPRITE_FROG, 0, 499, 1, 1, -1);
    #2;
    i_Rst_L = 1'b0;
    #1;
    check("async_reset_outputs",
          {o_Wr_En, o_Wr_Sel, o_Wr_Addr, o_Wr_Data, o_Busy, o_Done, o_Error}, 0);
    repeat (2) @(negedge i_Clk);
    i_Rst_L = 1'b1;
    @(negedge i_Clk);
    for (int i = 500; i < NPIX; i++) pix[i] = 9'h012;
    send_pixels(SPRITE_FROG, 500, NPIX - 1, 0, 0, -1);
    repeat (4) @(negedge i_Clk);
    check("post_reset_no_writes", exp_q.size(), 0);
    check("post_reset_busy", o_Busy, 0);
    fill_random();
    start_frame(SPRITE_CAR);
    send_pixels(SPRITE_CAR, 0, NPIX - 1, 1, 1, -1);
    finish_frame();
    expect_idle_ok("post_reset_frame");

`ifdef SPRITE_LOADER_CHECKSUM_EN
    fill_random();
    start_frame(SPRITE_FROG);
    send_pixels(SPRITE_FROG, 0, NPIX - 1, 1, 1, -1);
    send_byte(csum_model ^ 8'h5A, rgap());
    repeat (4) @(negedge i_Clk);
    check("bad_csum_error", o_Error, 1);
    check("bad_csum_no_done", done_seen, done_exp);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
